// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage:
// state encoding, reset instruction and PC legality helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam int          MEM_DEPTH_DEF = 256;
    localparam longint      IMEM_BYTES    = MEM_DEPTH_DEF * 4;

    // Word aligned and inside the fetchable byte range.
    function automatic logic pc_legal(
        input logic [63:0] pc,
        input logic [63:0] limit
    );
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush clears valid, load captures,
// otherwise contents hold.
import fetch_pkg::*;

module if_id_reg #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  flush,
    input  logic [INST_WIDTH-1:0] fetch_inst,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  id_valid,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [PC_WIDTH-1:0]   id_pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_inst     <= INST_WIDTH'(NOP_INST);
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_inst     <= fetch_inst;
            id_pc       <= fetch_pc;
            id_pc_plus4 <= fetch_pc + PC_WIDTH'(4);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, redirect/halt/fault
// control FSM, and the IF/ID handoff to decode.
import fetch_pkg::*;

module fetch_unit #(
    parameter int                PC_WIDTH     = 32,
    parameter int                INST_WIDTH   = 32,
    parameter int                MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  halt_req,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [PC_WIDTH-1:0]   id_pc_plus4,
    output logic                  fetch_fault,
    output logic [PC_WIDTH-1:0]   fault_pc,
    output logic [1:0]            state_o
);

    localparam logic [63:0] LIMIT = 64'(MEM_DEPTH) * 64'd4;

    state_t              state;
    state_t              state_nx;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_nx;
    logic [PC_WIDTH-1:0] fault_addr;
    logic                pc_ok;
    logic                tgt_ok;
    logic                load;
    logic                run_fetch;
    logic                capture;
    logic                flush;
    logic                fault_set;
    logic                fault_clr;

    assign pc_ok     = pc_legal(64'(pc_q), LIMIT);
    assign tgt_ok    = pc_legal(64'(redirect_pc), LIMIT);
    assign load      = !id_valid || id_ready;
    assign run_fetch = (state == ST_RUN) && !redirect_valid
                       && !halt_req && load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                state_nx = (redirect_valid && !tgt_ok) ? ST_FAULT : ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid)
                    state_nx = !tgt_ok ? ST_FAULT
                             : halt_req ? ST_HALTED : ST_RUN;
                else if (halt_req)
                    state_nx = ST_HALTED;
                else if (load && !pc_ok)
                    state_nx = ST_FAULT;
            end
            ST_HALTED: begin
                if (redirect_valid)
                    state_nx = !tgt_ok ? ST_FAULT
                             : halt_req ? ST_HALTED : ST_RUN;
                else if (!halt_req)
                    state_nx = ST_RUN;
            end
            ST_FAULT: begin
                if (redirect_valid && tgt_ok) state_nx = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_nx      = pc_q;
        capture    = 1'b0;
        flush      = 1'b0;
        fault_set  = 1'b0;
        fault_clr  = 1'b0;
        fault_addr = pc_q;
        unique case (1'b1)
            redirect_valid: begin
                pc_nx      = redirect_pc;
                flush      = 1'b1;
                fault_addr = redirect_pc;
                fault_set  = !tgt_ok;
                fault_clr  = tgt_ok && (state == ST_FAULT);
            end
            run_fetch: begin
                if (pc_ok) begin
                    capture = 1'b1;
                    pc_nx   = pc_q + PC_WIDTH'(4);
                end else begin
                    flush     = 1'b1;
                    fault_set = 1'b1;
                end
            end
            default: ;
        endcase
        // Decode took the current entry and nothing replaces it.
        if (!capture && id_ready) flush = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else begin
            pc_q <= pc_nx;
            if (fault_set) begin
                fetch_fault <= 1'b1;
                fault_pc    <= fault_addr;
            end else if (fault_clr) begin
                fetch_fault <= 1'b0;
            end
        end
    end

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (capture),
        .flush       (flush),
        .fetch_inst  (imem_inst),
        .fetch_pc    (pc_q),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    assign imem_pc = pc_q;
    assign state_o = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected fetch PCs popped on
// each decode handshake, plus directed checks of control events.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [1:0]  state_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory returns the word index as the instruction.
    assign imem_inst = {2'b00, imem_pc[31:2]};

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .state_o        (state_o)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", id_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", id_pc, e);
                check("sb_inst", id_inst, e >> 2);
                check("sb_pc4", id_pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        id_ready       = 1'b1;
        repeat (2) tick();
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_pc4", id_pc_plus4, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_imem_pc", imem_pc, 32'd0);

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_one_cycle", {30'd0, state_o}, 32'd1);
        check("idle_no_load", {31'd0, id_valid}, 32'd0);
        tick();
        check("first_pc", id_pc, 32'h0);
        tick();
        tick();
        check("third_pc", id_pc, 32'h8);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", id_pc, 32'h8);
            check("stall_inst", id_inst, 32'd2);
            check("stall_imem", imem_pc, 32'hC);
        end
        id_ready = 1'b1;
        tick();
        check("resume_pc", id_pc, 32'hC);

        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check("flush_valid", {31'd0, id_valid}, 32'd0);
        check("redir_imem", imem_pc, 32'h40);
        redirect_valid = 1'b0;
        tick();
        check("redir_pc", id_pc, 32'h40);
        check("redir_valid", {31'd0, id_valid}, 32'd1);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check("mis_fault", {31'd0, fetch_fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h42);
        check("mis_state", {30'd0, state_o}, 32'd3);
        check("mis_valid", {31'd0, id_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("fault_sticky", {30'd0, state_o}, 32'd3);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        id_ready       = 1'b1;
        for (int a = 32'h80; a < 32'h400; a += 4)
            exp_q.push_back(32'(a));
        tick();
        redirect_valid = 1'b0;
        check("clr_state", {30'd0, state_o}, 32'd1);
        check("clr_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        check("clr_pc", id_pc, 32'h80);
        for (int i = 0; i < 400 && state_o != 2'd3; i++) tick();
        check("range_state", {30'd0, state_o}, 32'd3);
        check("range_fault", {31'd0, fetch_fault}, 32'd1);
        check("range_fault_pc", fault_pc, 32'h400);
        check("range_valid", {31'd0, id_valid}, 32'd0);
        check("range_drain", 32'(exp_q.size()), 32'd0);

        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && id_pc != 32'h10; i++) tick();
        check("halt_reach", id_pc, 32'h10);
        id_ready = 1'b0;
        halt_req = 1'b1;
        tick();
        check("halt_state", {30'd0, state_o}, 32'd2);
        check("halt_pending", {31'd0, id_valid}, 32'd1);
        check("halt_pc", id_pc, 32'h10);
        id_ready = 1'b1;
        tick();
        check("halt_drain", {31'd0, id_valid}, 32'd0);
        tick();
        check("halt_no_cap", {31'd0, id_valid}, 32'd0);
        check("halt_imem", imem_pc, 32'h14);
        exp_q.push_back(32'h14);
        halt_req = 1'b0;
        tick();
        check("resume_state", {30'd0, state_o}, 32'd1);
        tick();
        check("resume_first", id_pc, 32'h14);
        tick();
        check("resume_next", id_pc, 32'h18);

        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        check("mid_rst_pc", id_pc, 32'd0);
        check("mid_rst_inst", id_inst, 32'd0);
        check("mid_rst_state", {30'd0, state_o}, 32'd0);
        check("mid_rst_imem", imem_pc, 32'd0);
        check("mid_rst_fault_pc", fault_pc, 32'd0);
        repeat (2) tick();
        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
